id_stage: RTL

- IF/ID pipeline register plus instruction decode for the 16-bit pipelined core.
- Sits directly upstream of the register file: drives its SrcReg1/SrcReg2 read indices and the destination/write-enable controls carried toward writeback.
- Detects load-use hazards against the instruction in ID/EX and stalls fetch.
- Applies branch flushes and latches HLT.

---
 rtl/id_stage_if.sv | 35 +++
 rtl/id_stage.sv | 95 +++++++++
 2 files changed

// File: rtl/id_stage_if.sv
// Bundle between fetch/EX and the ID stage: fetch slot, hazard/flush inputs,
// and the decoded-instruction controls that feed the register file and ID/EX.
interface id_stage_if #(parameter int DW = 16);
    logic [DW-1:0] if_instr;
    logic [DW-1:0] if_pc_plus2;
    logic          if_valid;
    logic          flush;
    logic          ex_mem_read;
    logic [3:0]    ex_dst_reg;

    logic          stall;
    logic          id_issue;
    logic [3:0]    src_reg1;
    logic [3:0]    src_reg2;
    logic [3:0]    dst_reg;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic [3:0]    alu_op;
    logic [DW-1:0] imm;
    logic [DW-1:0] id_pc_plus2;
    logic          halt;

    modport master (
        input  if_instr, if_pc_plus2, if_valid, flush, ex_mem_read, ex_dst_reg,
        output stall, id_issue, src_reg1, src_reg2, dst_reg, reg_write,
               mem_read, mem_write, alu_op, imm, id_pc_plus2, halt
    );

    modport slave (
        output if_instr, if_pc_plus2, if_valid, flush, ex_mem_read, ex_dst_reg,
        input  stall, id_issue, src_reg1, src_reg2, dst_reg, reg_write,
               mem_read, mem_write, alu_op, imm, id_pc_plus2, halt
    );
endinterface

// File: rtl/id_stage.sv
// IF/ID pipeline register, instruction decode, load-use stall and sticky halt.
//   state    | meaning
//   S_RUN    | normal issue from the IF/ID register
//   S_HALTED | HLT has issued; fetch frozen until reset
module id_stage #(parameter int DW = 16) (
    input  logic        clk,
    input  logic        rst,
    id_stage_if.master  bus
);
    localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6;
    localparam logic [3:0] OP_LW  = 4'h8, OP_SW  = 4'h9, OP_LLB = 4'hA, OP_LHB = 4'hB;
    localparam logic [3:0] OP_B   = 4'hC, OP_BR  = 4'hD, OP_PCS = 4'hE, OP_HLT = 4'hF;

    typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] id_instr, id_pc_q;
    logic          id_valid;
    logic [3:0]    opcode, rd, rs, rt;
    logic [3:0]    src1, src2;
    logic          halted, uses_src1, uses_src2, load_use, stall_i, issue_i;
    logic          reg_write_i;
    logic [DW-1:0] imm_i;

    assign opcode = id_instr[15:12];
    assign rd     = id_instr[11:8];
    assign rs     = id_instr[7:4];
    assign rt     = id_instr[3:0];

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_RUN && issue_i && opcode == OP_HLT)
            state_d = S_HALTED;
    end

    always_comb begin
        halted = (state_q == S_HALTED);
    end

    // Flush outranks both stall and halt; only id_valid is cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_instr <= '0;
            id_pc_q  <= '0;
            id_valid <= 1'b0;
        end else if (bus.flush) begin
            id_valid <= 1'b0;
        end else if (!stall_i) begin
            id_instr <= bus.if_instr;
            id_pc_q  <= bus.if_pc_plus2;
            id_valid <= bus.if_valid;
        end
    end

    always_comb begin
        src1        = (opcode == OP_LLB || opcode == OP_LHB) ? rd : rs;
        src2        = (opcode == OP_SW) ? rd : rt;
        uses_src1   = (opcode <= OP_LHB) || (opcode == OP_BR);
        uses_src2   = (opcode <= 4'h3) || (opcode == 4'h7) || (opcode == OP_SW);
        reg_write_i = (opcode <= OP_LW) || (opcode == OP_LLB) ||
                      (opcode == OP_LHB) || (opcode == OP_PCS);
        imm_i       = '0;
        case (opcode)
            OP_SLL, OP_SRA, OP_ROR: imm_i = {12'b0, id_instr[3:0]};
            OP_LW, OP_SW:           imm_i = {{11{id_instr[3]}}, id_instr[3:0], 1'b0};
            OP_LLB, OP_LHB:         imm_i = {8'b0, id_instr[7:0]};
            OP_B:                   imm_i = {{6{id_instr[8]}}, id_instr[8:0], 1'b0};
            default:                imm_i = '0;
        endcase
    end

    assign load_use = id_valid && bus.ex_mem_read &&
                      ((uses_src1 && src1 == bus.ex_dst_reg) ||
                       (uses_src2 && src2 == bus.ex_dst_reg));
    assign stall_i  = halted || load_use;
    assign issue_i  = id_valid && !stall_i && !bus.flush && !halted;

    assign bus.stall       = stall_i;
    assign bus.id_issue    = issue_i;
    assign bus.src_reg1    = src1;
    assign bus.src_reg2    = src2;
    assign bus.dst_reg     = rd;
    assign bus.reg_write   = id_valid && reg_write_i;
    assign bus.mem_read    = id_valid && (opcode == OP_LW);
    assign bus.mem_write   = id_valid && (opcode == OP_SW);
    assign bus.alu_op      = opcode;
    assign bus.imm         = imm_i;
    assign bus.id_pc_plus2 = id_pc_q;
    assign bus.halt        = halted;
endmodule
